// File: rtl/ipf_pkg.sv
// Shared definitions for the IPF LCU feeder: FSM states, frame geometry,
// parameter-word field layout and LCU size helpers.
package ipf_pkg;

  localparam int IMG_W = 128;
  localparam int PAR_W = 24;

  localparam int TYPE_LSB = 22;
  localparam int TYPE_W   = 2;
  localparam int BAND_LSB = 17;
  localparam int BAND_W   = 5;
  localparam int WO_BIT   = 16;
  localparam int OFF_LSB  = 0;
  localparam int OFF_W    = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PARAM,
    ST_PLOAD,
    ST_STREAM,
    ST_GAP,
    ST_WAIT,
    ST_DONE
  } state_t;

  // LCU edge length in pixels: 16, 32, 64 (128 for the unused code 3).
  function automatic logic [7:0] lcu_side(input logic [1:0] size);
    return 8'd16 << size;
  endfunction

  // LCUs along one frame edge: 8, 4, 2 (1 for the unused code 3).
  function automatic logic [3:0] lcus_per_side(input logic [1:0] size);
    return 4'd8 >> size;
  endfunction

endpackage

// File: rtl/ipf_lcu_addr_gen.sv
// LCU position and in-LCU row/col counters, wrap/last flags and the
// image/parameter RAM address arithmetic.
module ipf_lcu_addr_gen #(
  parameter int IMG_W = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  size,
  input  logic        clear,
  input  logic        col_inc,
  input  logic        row_next,
  input  logic        lcu_next,
  output logic [2:0]  lcu_x,
  output logic [2:0]  lcu_y,
  output logic        col_last,
  output logic        row_last,
  output logic        lcu_last,
  output logic [13:0] img_addr,
  output logic [5:0]  par_addr
);
  import ipf_pkg::*;

  logic [6:0]  col_reg;
  logic [6:0]  row_reg;
  logic [2:0]  x_reg;
  logic [2:0]  y_reg;
  logic [7:0]  side;
  logic [3:0]  per_side;
  logic        x_last;
  logic [13:0] row_abs;
  logic [13:0] col_abs;

  assign side     = lcu_side(size);
  assign per_side = lcus_per_side(size);

  assign col_last = ({1'b0, col_reg} == side - 8'd1);
  assign row_last = ({1'b0, row_reg} == side - 8'd1);
  assign x_last   = ({1'b0, x_reg} == per_side - 4'd1);
  assign lcu_last = x_last && ({1'b0, y_reg} == per_side - 4'd1);

  // Every legal LCU lies inside the frame, so 14 bits never overflow.
  assign row_abs  = 14'(y_reg) * 14'(side) + 14'(row_reg);
  assign col_abs  = 14'(x_reg) * 14'(side) + 14'(col_reg);
  assign img_addr = row_abs * 14'(IMG_W) + col_abs;
  assign par_addr = 6'(y_reg) * 6'(per_side) + 6'(x_reg);

  assign lcu_x = x_reg;
  assign lcu_y = y_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_reg <= '0;
      row_reg <= '0;
      x_reg   <= '0;
      y_reg   <= '0;
    end else if (clear) begin
      col_reg <= '0;
      row_reg <= '0;
      x_reg   <= '0;
      y_reg   <= '0;
    end else if (lcu_next) begin
      col_reg <= '0;
      row_reg <= '0;
      if (x_last) begin
        x_reg <= '0;
        y_reg <= y_reg + 3'd1;
      end else begin
        x_reg <= x_reg + 3'd1;
      end
    end else if (row_next) begin
      row_reg <= row_reg + 7'd1;
      col_reg <= '0;
    end else if (col_inc) begin
      col_reg <= col_reg + 7'd1;
    end
  end

endmodule

// File: rtl/ipf_lcu_feeder.sv
// Walks the frame LCU by LCU, loads per-LCU filter parameters and streams
// pixels row-major into the IPF under its busy back-pressure.
module ipf_lcu_feeder #(
  parameter int IMG_W = 128,
  parameter int PAR_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       size_sel,
  input  logic             busy,
  output logic             img_rd,
  output logic [13:0]      img_addr,
  input  logic [7:0]       img_q,
  output logic             par_rd,
  output logic [5:0]       par_addr,
  input  logic [PAR_W-1:0] par_q,
  output logic             in_en,
  output logic [7:0]       din,
  output logic [1:0]       ipf_type,
  output logic [4:0]       ipf_band_pos,
  output logic             ipf_wo_class,
  output logic [15:0]      ipf_offset,
  output logic [2:0]       lcu_x,
  output logic [2:0]       lcu_y,
  output logic [1:0]       lcu_size,
  output logic             done
);
  import ipf_pkg::*;

  state_t     state_reg;
  logic [1:0] size_reg;
  logic       start_ok;
  logic       rd_go;
  logic       wait_go;
  logic       col_inc;
  logic       row_next;
  logic       lcu_next;
  logic       col_last;
  logic       row_last;
  logic       lcu_last;

  assign start_ok = start && (state_reg == ST_IDLE || state_reg == ST_DONE);
  // Reads depend on same-cycle busy so nothing is issued into a stalled IPF.
  assign rd_go    = (state_reg == ST_STREAM) && !busy;
  assign wait_go  = (state_reg == ST_WAIT) && !busy;
  assign col_inc  = rd_go && !col_last;
  assign row_next = wait_go && !row_last;
  assign lcu_next = wait_go && row_last && !lcu_last;

  assign img_rd   = rd_go;
  assign par_rd   = (state_reg == ST_PARAM);
  assign done     = (state_reg == ST_DONE);
  assign din      = img_q;
  assign lcu_size = size_reg;

  ipf_lcu_addr_gen #(
    .IMG_W(IMG_W)
  ) u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .size     (size_reg),
    .clear    (start_ok),
    .col_inc  (col_inc),
    .row_next (row_next),
    .lcu_next (lcu_next),
    .lcu_x    (lcu_x),
    .lcu_y    (lcu_y),
    .col_last (col_last),
    .row_last (row_last),
    .lcu_last (lcu_last),
    .img_addr (img_addr),
    .par_addr (par_addr)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= ST_IDLE;
      size_reg     <= '0;
      in_en        <= 1'b0;
      ipf_type     <= '0;
      ipf_band_pos <= '0;
      ipf_wo_class <= 1'b0;
      ipf_offset   <= '0;
    end else begin
      in_en <= rd_go;
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            size_reg  <= size_sel;
            state_reg <= ST_PARAM;
          end
        end
        ST_PARAM: state_reg <= ST_PLOAD;
        ST_PLOAD: begin
          ipf_type     <= par_q[TYPE_LSB +: TYPE_W];
          ipf_band_pos <= par_q[BAND_LSB +: BAND_W];
          ipf_wo_class <= par_q[WO_BIT];
          ipf_offset   <= par_q[OFF_LSB +: OFF_W];
          state_reg    <= ST_STREAM;
        end
        ST_STREAM: begin
          if (rd_go && col_last) state_reg <= ST_GAP;
        end
        // One idle cycle lets busy react to the row-ending pixel.
        ST_GAP: state_reg <= ST_WAIT;
        ST_WAIT: begin
          if (!busy) begin
            if (!row_last)      state_reg <= ST_STREAM;
            else if (!lcu_last) state_reg <= ST_PARAM;
            else                state_reg <= ST_DONE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ipf_lcu_feeder.sv
// Directed bench for ipf_lcu_feeder with image/parameter RAM models and a
// behavioural IPF busy model; per-cycle checks run inside tick().
module tb_ipf_lcu_feeder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  size_sel = 2'd0;
  logic        busy = 1'b0;
  logic        img_rd;
  logic [13:0] img_addr;
  logic [7:0]  img_q;
  logic        par_rd;
  logic [5:0]  par_addr;
  logic [23:0] par_q;
  logic        in_en;
  logic [7:0]  din;
  logic [1:0]  ipf_type;
  logic [4:0]  ipf_band_pos;
  logic        ipf_wo_class;
  logic [15:0] ipf_offset;
  logic [2:0]  lcu_x;
  logic [2:0]  lcu_y;
  logic [1:0]  lcu_size;
  logic        done;

  always #5 clk = ~clk;

  ipf_lcu_feeder #(.IMG_W(128), .PAR_W(24)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .size_sel     (size_sel),
    .busy         (busy),
    .img_rd       (img_rd),
    .img_addr     (img_addr),
    .img_q        (img_q),
    .par_rd       (par_rd),
    .par_addr     (par_addr),
    .par_q        (par_q),
    .in_en        (in_en),
    .din          (din),
    .ipf_type     (ipf_type),
    .ipf_band_pos (ipf_band_pos),
    .ipf_wo_class (ipf_wo_class),
    .ipf_offset   (ipf_offset),
    .lcu_x        (lcu_x),
    .lcu_y        (lcu_y),
    .lcu_size     (lcu_size),
    .done         (done)
  );

  function automatic logic [7:0] pix(input logic [13:0] a);
    return a[7:0] ^ {a[13:8], a[1:0]};
  endfunction

  function automatic logic [23:0] par_word(input int i);
    if (i == 5) return 24'hA53C7E;
    return 24'h5A1234 ^ (24'(i) * 24'h013579);
  endfunction

  // Busy hold length after the g-th completed row of a run.
  function automatic int hold_for(input int g);
    if (g == 3) return 37;
    if (g % 5 == 0) return 4;
    return 0;
  endfunction

  always_ff @(posedge clk) begin
    if (img_rd) img_q <= pix(img_addr);
    if (par_rd) par_q <= par_word(int'(par_addr));
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 0;
  int s_cur = 16;
  int exp_addr[$];
  int exp_par[$];
  int ai, pi, in_cnt, par_cnt, rd_in_lcu, pix_in_row, row_done, hold, cur_lcu;
  int last_rd_cyc, next_gap;
  bit have_rd, rd_d;
  logic [13:0] addr_d;
  int first_addr[64];
  int par_log[64];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic build_exp(input int sz);
    int s, n;
    s = 16 << sz;
    n = 8 >> sz;
    s_cur = s;
    exp_addr.delete();
    exp_par.delete();
    for (int ly = 0; ly < n; ly++)
      for (int lx = 0; lx < n; lx++) begin
        exp_par.push_back(ly * n + lx);
        for (int r = 0; r < s; r++)
          for (int c = 0; c < s; c++)
            exp_addr.push_back((ly * s + r) * 128 + lx * s + c);
      end
    ai = 0; pi = 0; in_cnt = 0; par_cnt = 0; rd_in_lcu = 0; pix_in_row = 0;
    row_done = 0; hold = 0; busy = 1'b0; rd_d = 0; have_rd = 0; cur_lcu = 0;
  endtask

  // Advance to the next falling edge and run the per-cycle monitor.
  task automatic tick();
    int h;
    logic [23:0] w;
    @(negedge clk);
    cyc++;
    if (!mon_en) return;
    if (busy) begin
      chk("bp_img_rd", img_rd, 0);
      chk("bp_in_en", in_en, 0);
    end
    if (hold > 0) begin
      hold--;
      if (hold == 0) busy = 1'b0;
    end
    chk("in_en_lat", in_en, rd_d);
    if (in_en) begin
      in_cnt++;
      chk("din", din, pix(addr_d));
      w = par_word(cur_lcu);
      chk("ipf_type", ipf_type, w[23:22]);
      chk("ipf_band_pos", ipf_band_pos, w[21:17]);
      chk("ipf_wo_class", ipf_wo_class, w[16]);
      chk("ipf_offset", ipf_offset, w[15:0]);
      if (cur_lcu == 5 && s_cur == 16) begin
        chk("lcu5_type", ipf_type, 2);
        chk("lcu5_band_pos", ipf_band_pos, 18);
        chk("lcu5_wo_class", ipf_wo_class, 1);
        chk("lcu5_offset", ipf_offset, 32'h3C7E);
      end
      pix_in_row++;
      if (pix_in_row == s_cur) begin
        pix_in_row = 0;
        row_done++;
        hold = hold_for(row_done);
        busy = (hold > 0);
      end
    end
    if (img_rd) begin
      if (have_rd) chk("rd_gap", cyc - last_rd_cyc, next_gap);
      have_rd = 1;
      last_rd_cyc = cyc;
      chk("img_addr", img_addr, ai < exp_addr.size() ? exp_addr[ai] : -1);
      if (rd_in_lcu == 0) first_addr[cur_lcu] = int'(img_addr);
      if (ai % s_cur == s_cur - 1) begin
        h = hold_for(ai / s_cur + 1);
        next_gap = ((h <= 1) ? 3 : 2 + h) + (((ai % (s_cur * s_cur)) == s_cur * s_cur - 1) ? 2 : 0);
      end else begin
        next_gap = 1;
      end
      ai++;
      rd_in_lcu++;
    end
    if (par_rd) begin
      chk("par_addr", par_addr, pi < exp_par.size() ? exp_par[pi] : -1);
      if (pi < 64) par_log[pi] = int'(par_addr);
      cur_lcu = (pi < exp_par.size()) ? exp_par[pi] : 0;
      pi++;
      par_cnt++;
      rd_in_lcu = 0;
    end
    rd_d = img_rd;
    addr_d = img_addr;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_in_en", in_en, 0);
    chk("rst_img_rd", img_rd, 0);
    chk("rst_img_addr", img_addr, 0);
    chk("rst_par_rd", par_rd, 0);
    chk("rst_par_addr", par_addr, 0);
    chk("rst_ipf_type", ipf_type, 0);
    chk("rst_ipf_band_pos", ipf_band_pos, 0);
    chk("rst_ipf_wo_class", ipf_wo_class, 0);
    chk("rst_ipf_offset", ipf_offset, 0);
    chk("rst_lcu_x", lcu_x, 0);
    chk("rst_lcu_y", lcu_y, 0);
    chk("rst_lcu_size", lcu_size, 0);
    chk("rst_done", done, 0);
  endtask

  // Pulse start and check the PARAM, PLOAD, read, in_en latency chain.
  task automatic do_start(input logic [1:0] sz);
    size_sel = sz;
    start = 1'b1;
    tick();
    start = 1'b0;
    size_sel = 2'd0;
    chk("st_par_rd", par_rd, 1);
    chk("st_par_addr", par_addr, 0);
    chk("st_size", lcu_size, sz);
    chk("st_done", done, 0);
    tick();
    chk("st_pload_par_rd", par_rd, 0);
    chk("st_pload_img_rd", img_rd, 0);
    tick();
    chk("st_first_rd", img_rd, 1);
    chk("st_first_addr", img_addr, 0);
    tick();
    chk("st_first_in_en", in_en, 1);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    chk("done_timeout", done, 1);
  endtask

  initial begin
    int n;

    // Reset state
    reset = 1'b0;
    repeat (3) tick();
    chk_reset_outputs();
    reset = 1'b1;
    tick();
    chk("idle_done", done, 0);

    // Size 0 run abandoned by reset during LCU 3, row 10
    build_exp(0);
    mon_en = 1;
    do_start(2'd0);
    n = 0;
    while (!(par_cnt == 4 && rd_in_lcu == 165) && n < 20000) begin
      tick();
      n++;
    end
    chk("reach_lcu3_row10", par_cnt * 1000 + rd_in_lcu, 4165);
    chk("pre_reset_lcu_x", lcu_x, 3);
    mon_en = 0;
    reset = 1'b0;
    #1;
    chk_reset_outputs();
    tick();
    tick();
    reset = 1'b1;
    tick();

    // Full size 0 frame from a fresh start; a start during STREAM is ignored
    build_exp(0);
    mon_en = 1;
    do_start(2'd0);
    n = 0;
    while (!(par_cnt == 2 && img_rd) && n < 2000) begin
      tick();
      n++;
    end
    chk("reach_lcu1_stream", par_cnt, 2);
    start = 1'b1;
    size_sel = 2'd2;
    tick();
    start = 1'b0;
    size_sel = 2'd0;
    chk("start_ignored_size", lcu_size, 0);
    wait_done(40000);
    chk("s0_in_en_count", in_cnt, 16384);
    chk("s0_par_rd_count", par_cnt, 64);
    chk("s0_reads_all", ai, exp_addr.size());
    chk("s0_first_addr_lcu1", first_addr[1], 16);

    // Restart from DONE with size 2
    tick();
    chk("done_held", done, 1);
    build_exp(2);
    do_start(2'd2);
    wait_done(40000);
    chk("s2_in_en_count", in_cnt, 16384);
    chk("s2_par_rd_count", par_cnt, 4);
    chk("s2_first_addr_lcu1", first_addr[1], 64);
    chk("s2_first_addr_lcu2", first_addr[2], 8192);
    chk("s2_first_addr_lcu3", first_addr[3], 8256);
    chk("s2_par_addr0", par_log[0], 0);
    chk("s2_par_addr1", par_log[1], 1);
    chk("s2_par_addr2", par_log[2], 2);
    chk("s2_par_addr3", par_log[3], 3);
    chk("s2_lcu_size", lcu_size, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
